// File: rtl/ext_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ext_bus_pkg                                               |
// | Purpose  : Shared types for the external bus arbiter: the arbiter    |
// |            state encoding and the default AXI ID width.              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+

`ifndef AXI_ID_LEN
`define AXI_ID_LEN 4
`endif

package ext_bus_pkg;

    // One whole transaction is owned at a time: address phase, data phase,
    // and (for writes) the response phase.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        RD   = 3'd2,
        AW   = 3'd3,
        WR   = 3'd4,
        WB   = 3'd5
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_picker                                                 |
// | Purpose  : Combinational round-robin selector. Returns the first     |
// |            asserted request at or after i_ptr, wrapping modulo       |
// |            NUM_REQ.                                                  |
// | Ports    : i_req   - request vector                                  |
// |            i_ptr   - highest-priority index this round               |
// |            o_valid - at least one request asserted                   |
// |            o_idx   - winning index (0 when o_valid is low)           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_picker #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic                       o_valid,
    output logic [$clog2(NUM_REQ)-1:0] o_idx
);

    localparam int GRANT_W = $clog2(NUM_REQ);

    // Scan from the farthest offset back to offset 0 so the candidate
    // closest to i_ptr is the last one written and therefore wins.
    always_comb begin
        int w_pos;
        o_valid = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_pos = (int'(i_ptr) + i) % NUM_REQ;
            if (i_req[w_pos]) begin
                o_valid = 1'b1;
                o_idx   = GRANT_W'(w_pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ext_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ext_bus_arbiter                                           |
// | Purpose  : Shares the single AXI slave port of the external bus      |
// |            bridge between NUM_REQ AXI masters, one whole read or     |
// |            write transaction at a time, round-robin.                 |
// | Ports    : clk, rst          - clock, async active-high reset        |
// |            s_axi_ar*/aw*/w*  - per-requester address/data, packed    |
// |            s_axi_r*/b*       - shared payload, per-requester valid   |
// |            m_axi_*           - single master port to the bridge      |
// |            OUT_busy          - a transaction is owned                |
// |            OUT_grant         - index of the owning requester         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ext_bus_arbiter
    import ext_bus_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_LEN = 32,
    parameter int WIDTH    = 32,
    parameter int ID_LEN   = `AXI_ID_LEN
) (
    input  logic                        clk,
    input  logic                        rst,
    // requester read address
    input  logic [NUM_REQ*ID_LEN-1:0]   s_axi_arid,
    input  logic [NUM_REQ*ADDR_LEN-1:0] s_axi_araddr,
    input  logic [NUM_REQ*8-1:0]        s_axi_arlen,
    input  logic [NUM_REQ*3-1:0]        s_axi_arsize,
    input  logic [NUM_REQ-1:0]          s_axi_arvalid,
    output logic [NUM_REQ-1:0]          s_axi_arready,
    // requester write address
    input  logic [NUM_REQ*ID_LEN-1:0]   s_axi_awid,
    input  logic [NUM_REQ*ADDR_LEN-1:0] s_axi_awaddr,
    input  logic [NUM_REQ*8-1:0]        s_axi_awlen,
    input  logic [NUM_REQ*3-1:0]        s_axi_awsize,
    input  logic [NUM_REQ-1:0]          s_axi_awvalid,
    output logic [NUM_REQ-1:0]          s_axi_awready,
    // requester write data
    input  logic [NUM_REQ*WIDTH-1:0]    s_axi_wdata,
    input  logic [NUM_REQ*WIDTH/8-1:0]  s_axi_wstrb,
    input  logic [NUM_REQ-1:0]          s_axi_wlast,
    input  logic [NUM_REQ-1:0]          s_axi_wvalid,
    output logic [NUM_REQ-1:0]          s_axi_wready,
    // requester read data (payload shared, valid per requester)
    output logic [ID_LEN-1:0]           s_axi_rid,
    output logic [WIDTH-1:0]            s_axi_rdata,
    output logic                        s_axi_rlast,
    output logic [NUM_REQ-1:0]          s_axi_rvalid,
    input  logic [NUM_REQ-1:0]          s_axi_rready,
    // requester write response
    output logic [ID_LEN-1:0]           s_axi_bid,
    output logic [NUM_REQ-1:0]          s_axi_bvalid,
    input  logic [NUM_REQ-1:0]          s_axi_bready,
    // bridge read address
    output logic [ID_LEN-1:0]           m_axi_arid,
    output logic [ADDR_LEN-1:0]         m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    // bridge write address
    output logic [ID_LEN-1:0]           m_axi_awid,
    output logic [ADDR_LEN-1:0]         m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    // bridge write data
    output logic [WIDTH-1:0]            m_axi_wdata,
    output logic [WIDTH/8-1:0]          m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    // bridge read data
    input  logic [ID_LEN-1:0]           m_axi_rid,
    input  logic [WIDTH-1:0]            m_axi_rdata,
    input  logic                        m_axi_rlast,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    // bridge write response
    input  logic [ID_LEN-1:0]           m_axi_bid,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    // status
    output logic                        OUT_busy,
    output logic [$clog2(NUM_REQ)-1:0]  OUT_grant
);

    localparam int GRANT_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic [ID_LEN-1:0]   id;
        logic [ADDR_LEN-1:0] addr;
        logic [7:0]          len;
        logic [2:0]          size;
    } arb_req_t;

    arb_state_e         r_state;
    logic [GRANT_W-1:0] r_grant;
    logic [GRANT_W-1:0] r_rr_ptr;
    logic [7:0]         r_beat_cnt;
    logic [7:0]         r_len;
    logic               r_w_pend;

    logic               w_pick_valid;
    logic [GRANT_W-1:0] w_pick_idx;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [GRANT_W-1:0] w_next_ptr;
    arb_req_t           w_ar_sel;
    arb_req_t           w_aw_sel;
    logic               w_ar_hs;
    logic               w_aw_hs;
    logic               w_r_beat;
    logic               w_w_beat;
    logic               w_b_hs;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req   (s_axi_arvalid | s_axi_awvalid),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    assign w_gnt_oh   = NUM_REQ'(1) << r_grant;
    assign w_next_ptr = (r_grant == GRANT_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

    assign w_ar_sel = '{id:   s_axi_arid  [r_grant*ID_LEN   +: ID_LEN],
                        addr: s_axi_araddr[r_grant*ADDR_LEN +: ADDR_LEN],
                        len:  s_axi_arlen [r_grant*8        +: 8],
                        size: s_axi_arsize[r_grant*3        +: 3]};
    assign w_aw_sel = '{id:   s_axi_awid  [r_grant*ID_LEN   +: ID_LEN],
                        addr: s_axi_awaddr[r_grant*ADDR_LEN +: ADDR_LEN],
                        len:  s_axi_awlen [r_grant*8        +: 8],
                        size: s_axi_awsize[r_grant*3        +: 3]};

    assign w_ar_hs  = (r_state == AR) && s_axi_arvalid[r_grant] && m_axi_arready;
    assign w_aw_hs  = (r_state == AW) && s_axi_awvalid[r_grant] && m_axi_awready;
    assign w_r_beat = (r_state == RD) && m_axi_rvalid && s_axi_rready[r_grant];
    assign w_w_beat = (r_state == WR) && s_axi_wvalid[r_grant] && m_axi_wready;
    assign w_b_hs   = (r_state == WB) && m_axi_bvalid && s_axi_bready[r_grant];

    // Address channels: payload always follows the grant, valid/ready only
    // in the owning phase so IDLE is a clean bubble.
    assign m_axi_arid    = w_ar_sel.id;
    assign m_axi_araddr  = w_ar_sel.addr;
    assign m_axi_arlen   = w_ar_sel.len;
    assign m_axi_arsize  = w_ar_sel.size;
    assign m_axi_arvalid = (r_state == AR) && s_axi_arvalid[r_grant];
    assign s_axi_arready = (r_state == AR && m_axi_arready) ? w_gnt_oh : '0;

    assign m_axi_awid    = w_aw_sel.id;
    assign m_axi_awaddr  = w_aw_sel.addr;
    assign m_axi_awlen   = w_aw_sel.len;
    assign m_axi_awsize  = w_aw_sel.size;
    assign m_axi_awvalid = (r_state == AW) && s_axi_awvalid[r_grant];
    assign s_axi_awready = (r_state == AW && m_axi_awready) ? w_gnt_oh : '0;

    assign m_axi_wdata   = s_axi_wdata[r_grant*WIDTH     +: WIDTH];
    assign m_axi_wstrb   = s_axi_wstrb[r_grant*(WIDTH/8) +: WIDTH/8];
    assign m_axi_wlast   = s_axi_wlast[r_grant];
    assign m_axi_wvalid  = (r_state == WR) && s_axi_wvalid[r_grant];
    assign s_axi_wready  = (r_state == WR && m_axi_wready) ? w_gnt_oh : '0;

    // Read/response payload is broadcast; only the owner sees valid. Stray
    // bridge valids outside RD/WB are never acknowledged.
    assign s_axi_rid     = m_axi_rid;
    assign s_axi_rdata   = m_axi_rdata;
    assign s_axi_rlast   = m_axi_rlast;
    assign s_axi_rvalid  = (r_state == RD && m_axi_rvalid) ? w_gnt_oh : '0;
    assign m_axi_rready  = (r_state == RD) && s_axi_rready[r_grant];

    assign s_axi_bid     = m_axi_bid;
    assign s_axi_bvalid  = (r_state == WB && m_axi_bvalid) ? w_gnt_oh : '0;
    assign m_axi_bready  = (r_state == WB) && s_axi_bready[r_grant];

    assign OUT_busy  = (r_state != IDLE);
    assign OUT_grant = r_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_len      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant    <= w_pick_idx;
                        r_beat_cnt <= '0;
                        // A read pending on the winner goes first; its write
                        // is picked up in a later round.
                        if (s_axi_arvalid[w_pick_idx]) begin
                            r_len   <= s_axi_arlen[w_pick_idx*8 +: 8];
                            r_state <= AR;
                        end else begin
                            r_len   <= s_axi_awlen[w_pick_idx*8 +: 8];
                            r_state <= AW;
                        end
                    end
                end
                AR: if (w_ar_hs) r_state <= RD;
                RD: begin
                    if (w_r_beat) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (m_axi_rlast) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                AW: if (w_aw_hs) r_state <= WR;
                WR: begin
                    if (w_w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (s_axi_wlast[r_grant]) r_state <= WB;
                    end
                end
                WB: begin
                    if (w_b_hs) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Remembers an offered-but-unaccepted W beat so a withdrawn wvalid can
    // be flagged on the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_w_pend <= 1'b0;
        else     r_w_pend <= (r_state == WR) && s_axi_wvalid[r_grant] && !m_axi_wready;
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (w_r_beat) assert (m_axi_rlast == (r_beat_cnt == r_len));
            if (w_w_beat) assert (s_axi_wlast[r_grant] == (r_beat_cnt == r_len));
            assert (!(m_axi_rvalid && r_state != RD));
            assert (!(m_axi_bvalid && r_state != WB));
            if (r_state == AR) assert (s_axi_arvalid[r_grant]);
            if (r_state == AW) assert (s_axi_awvalid[r_grant]);
            if (r_w_pend)      assert (s_axi_wvalid[r_grant]);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ext_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ext_bus_arbiter                                        |
// | Purpose  : Directed self-checking bench for ext_bus_arbiter with     |
// |            three requesters and a hand-driven bridge.                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_ext_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [N*IW-1:0]   s_axi_arid = '0,   s_axi_awid = '0;
    logic [N*AW-1:0]   s_axi_araddr = '0, s_axi_awaddr = '0;
    logic [N*8-1:0]    s_axi_arlen = '0,  s_axi_awlen = '0;
    logic [N*3-1:0]    s_axi_arsize = '0, s_axi_awsize = '0;
    logic [N-1:0]      s_axi_arvalid = '0, s_axi_awvalid = '0;
    logic [N-1:0]      s_axi_arready, s_axi_awready;
    logic [N*DW-1:0]   s_axi_wdata = '0;
    logic [N*DW/8-1:0] s_axi_wstrb = '0;
    logic [N-1:0]      s_axi_wlast = '0, s_axi_wvalid = '0;
    logic [N-1:0]      s_axi_wready;
    logic [IW-1:0]     s_axi_rid, s_axi_bid;
    logic [DW-1:0]     s_axi_rdata;
    logic              s_axi_rlast;
    logic [N-1:0]      s_axi_rvalid, s_axi_bvalid;
    logic [N-1:0]      s_axi_rready = '0, s_axi_bready = '0;
    logic [IW-1:0]     m_axi_arid, m_axi_awid;
    logic [AW-1:0]     m_axi_araddr, m_axi_awaddr;
    logic [7:0]        m_axi_arlen, m_axi_awlen;
    logic [2:0]        m_axi_arsize, m_axi_awsize;
    logic              m_axi_arvalid, m_axi_awvalid;
    logic              m_axi_arready = 1'b0, m_axi_awready = 1'b0;
    logic [DW-1:0]     m_axi_wdata;
    logic [DW/8-1:0]   m_axi_wstrb;
    logic              m_axi_wlast, m_axi_wvalid;
    logic              m_axi_wready = 1'b0;
    logic [IW-1:0]     m_axi_rid = '0, m_axi_bid = '0;
    logic [DW-1:0]     m_axi_rdata = '0;
    logic              m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0;
    logic              m_axi_rready;
    logic              m_axi_bvalid = 1'b0;
    logic              m_axi_bready;
    logic              OUT_busy;
    logic [1:0]        OUT_grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ext_bus_arbiter #(
        .NUM_REQ(N), .ADDR_LEN(AW), .WIDTH(DW), .ID_LEN(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_bid(s_axi_bid), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_bid(m_axi_bid), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .OUT_busy(OUT_busy), .OUT_grant(OUT_grant)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow #1 later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // One single-beat read completion from the bridge while in RD.
    task automatic one_beat(input logic [31:0] data);
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b1;
        m_axi_rdata  = data;
        cyc();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
    endtask

    int exp_g [4] = '{2, 0, 1, 2};
    int gaps  [8] = '{1, 0, 2, 3, 0, 1, 0, 2};

    initial begin
        // ---------------- reset state ----------------
        cyc();
        #1;
        chk("rst_busy",    OUT_busy, 0);
        chk("rst_grant",   OUT_grant, 0);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_rready",  m_axi_rready, 0);
        cyc();
        rst = 1'b0;

        // ---------------- single read, req1, len 3 ----------------
        s_axi_arvalid           = 3'b010;
        s_axi_araddr[1*AW +: AW] = 32'h0000_1000;
        s_axi_arlen[1*8 +: 8]   = 8'd3;
        s_axi_arsize[1*3 +: 3]  = 3'd2;
        s_axi_arid[1*IW +: IW]  = 4'h5;
        m_axi_arready           = 1'b1;
        s_axi_rready            = 3'b111;
        #1;
        chk("idle_busy",    OUT_busy, 0);
        chk("idle_arvalid", m_axi_arvalid, 0);
        cyc();
        #1;
        chk("ar_busy",    OUT_busy, 1);
        chk("ar_grant",   OUT_grant, 1);
        chk("ar_valid",   m_axi_arvalid, 1);
        chk("ar_addr",    m_axi_araddr, 32'h0000_1000);
        chk("ar_len",     m_axi_arlen, 3);
        chk("ar_id",      m_axi_arid, 5);
        chk("ar_ready",   s_axi_arready, 3'b010);
        cyc();
        s_axi_arvalid = 3'b000;
        m_axi_rvalid  = 1'b1;
        m_axi_rid     = 4'h5;
        m_axi_rdata   = 32'hA0;
        s_axi_rready  = 3'b101;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_rready", m_axi_rready, 0);
            chk("bp_rvalid", s_axi_rvalid, 3'b010);
            cyc();
        end
        s_axi_rready = 3'b111;
        for (int b = 0; b < 4; b++) begin
            m_axi_rdata = 32'hA0 + b;
            m_axi_rlast = (b == 3);
            #1;
            chk("rd_data",   s_axi_rdata, 32'hA0 + b);
            chk("rd_last",   s_axi_rlast, (b == 3));
            chk("rd_valid",  s_axi_rvalid, 3'b010);
            chk("rd_rready", m_axi_rready, 1);
            chk("rd_id",     s_axi_rid, 5);
            cyc();
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        #1;
        chk("rd_done_busy", OUT_busy, 0);

        // ---------------- round robin, pointer now at 2 ----------------
        s_axi_arvalid = 3'b111;
        for (int i = 0; i < N; i++) begin
            s_axi_araddr[i*AW +: AW] = 32'h100 * (i + 1);
            s_axi_arlen[i*8 +: 8]    = 8'd0;
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            #1;
            chk("rr_grant", OUT_grant, exp_g[k]);
            chk("rr_addr",  m_axi_araddr, 32'h100 * (exp_g[k] + 1));
            cyc();
            #1;
            m_axi_rvalid = 1'b1;
            #1;
            chk("rr_rvalid", s_axi_rvalid, 64'd1 << exp_g[k]);
            m_axi_rvalid = 1'b0;
            one_beat(32'hBEEF_0000 + k);
        end
        s_axi_arvalid = 3'b000;

        // -------- req0 read+write together, req1 read pending --------
        s_axi_arvalid            = 3'b011;
        s_axi_awvalid            = 3'b001;
        s_axi_araddr[0*AW +: AW] = 32'h0000_4000;
        s_axi_araddr[1*AW +: AW] = 32'h0000_3000;
        s_axi_awaddr[0*AW +: AW] = 32'h0000_2000;
        s_axi_awlen[0*8 +: 8]    = 8'd7;
        s_axi_awid[0*IW +: IW]   = 4'h6;
        m_axi_awready            = 1'b1;
        m_axi_wready             = 1'b1;
        cyc();
        #1;
        chk("rw_first_grant", OUT_grant, 0);
        chk("rw_first_ar",    m_axi_arvalid, 1);
        chk("rw_first_aw",    m_axi_awvalid, 0);
        chk("rw_first_addr",  m_axi_araddr, 32'h0000_4000);
        cyc();
        s_axi_arvalid = 3'b010;
        one_beat(32'h1111);
        cyc();
        #1;
        chk("rw_second_grant", OUT_grant, 1);
        chk("rw_second_addr",  m_axi_araddr, 32'h0000_3000);
        cyc();
        s_axi_arvalid = 3'b000;
        one_beat(32'h2222);
        s_axi_wvalid = 3'b001;
        cyc();
        #1;
        chk("aw_grant",  OUT_grant, 0);
        chk("aw_valid",  m_axi_awvalid, 1);
        chk("aw_addr",   m_axi_awaddr, 32'h0000_2000);
        chk("aw_len",    m_axi_awlen, 7);
        chk("aw_id",     m_axi_awid, 6);
        chk("aw_wvalid", m_axi_wvalid, 0);
        chk("aw_wready", s_axi_wready, 0);
        cyc();
        s_axi_awvalid = 3'b000;
        s_axi_wvalid  = 3'b000;
        for (int b = 0; b < 8; b++) begin
            s_axi_wvalid = 3'b000;
            for (int g = 0; g < gaps[b]; g++) begin
                #1;
                chk("w_gap", m_axi_wvalid, 0);
                cyc();
            end
            s_axi_wvalid         = 3'b001;
            s_axi_wdata[0 +: DW] = 32'hD000_0000 + b;
            s_axi_wstrb[0 +: 4]  = 4'hF ^ 4'(b);
            s_axi_wlast          = (b == 7) ? 3'b001 : 3'b000;
            #1;
            chk("w_valid", m_axi_wvalid, 1);
            chk("w_data",  m_axi_wdata, 32'hD000_0000 + b);
            chk("w_strb",  m_axi_wstrb, 4'hF ^ 4'(b));
            chk("w_last",  m_axi_wlast, (b == 7));
            chk("w_ready", s_axi_wready, 3'b001);
            cyc();
        end
        s_axi_wvalid = 3'b000;
        s_axi_wlast  = 3'b000;
        m_axi_bvalid = 1'b1;
        m_axi_bid    = 4'h6;
        s_axi_bready = 3'b111;
        #1;
        chk("wb_bvalid", s_axi_bvalid, 3'b001);
        chk("wb_bready", m_axi_bready, 1);
        chk("wb_bid",    s_axi_bid, 6);
        chk("wb_wvalid", m_axi_wvalid, 0);
        cyc();
        m_axi_bvalid = 1'b0;
        #1;
        chk("wb_done_busy", OUT_busy, 0);

        // ---------------- async reset in the middle of a read ----------------
        s_axi_arvalid            = 3'b010;
        s_axi_araddr[1*AW +: AW] = 32'h0000_5000;
        s_axi_arlen[1*8 +: 8]    = 8'd3;
        cyc();
        #1;
        chk("mid_grant", OUT_grant, 1);
        cyc();
        s_axi_arvalid = 3'b000;
        m_axi_rvalid  = 1'b1;
        m_axi_rlast   = 1'b0;
        cyc();
        cyc();
        #1;
        chk("mid_beat2_valid", s_axi_rvalid, 3'b010);
        rst = 1'b1;
        #1;
        chk("arst_busy",   OUT_busy, 0);
        chk("arst_rvalid", s_axi_rvalid, 0);
        chk("arst_rready", m_axi_rready, 0);
        chk("arst_grant",  OUT_grant, 0);
        m_axi_rvalid = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        // Pointer back at 0 means req0 is served before req2.
        s_axi_arvalid            = 3'b101;
        s_axi_araddr[0*AW +: AW] = 32'h0000_6000;
        s_axi_araddr[2*AW +: AW] = 32'h0000_7000;
        s_axi_arlen[0*8 +: 8]    = 8'd0;
        s_axi_arlen[2*8 +: 8]    = 8'd0;
        cyc();
        #1;
        chk("post_grant0", OUT_grant, 0);
        cyc();
        s_axi_arvalid = 3'b100;
        one_beat(32'h3333);
        cyc();
        #1;
        chk("post_grant2", OUT_grant, 2);
        chk("post_addr2",  m_axi_araddr, 32'h0000_7000);
        cyc();
        s_axi_arvalid = 3'b000;
        m_axi_rvalid  = 1'b1;
        m_axi_rlast   = 1'b1;
        m_axi_rdata   = 32'h4444;
        #1;
        chk("post_rvalid2", s_axi_rvalid, 3'b100);
        cyc();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        #1;
        chk("post_busy", OUT_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
